// File: rtl/addsub96_arb.sv
// addsub96_arb: two-requester round-robin front end for a shared, externally
// pipelined 95-bit adder/subtractor. Grants one operation per cycle, registers
// the operands toward the adder, and routes each LAT-delayed SUM_OUT back to the
// requester that issued it, in acceptance order.
module addsub96_arb #(
  parameter int LAT = 2  // adder latency from registered AIN/BIN/ADD_SUB to SUM_OUT, 1..8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [94:0] REQ0_A,
  input  logic [94:0] REQ0_B,
  input  logic        REQ0_SUB,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [94:0] REQ1_A,
  input  logic [94:0] REQ1_B,
  input  logic        REQ1_SUB,
  output logic [94:0] AIN,
  output logic [94:0] BIN,
  output logic        ADD_SUB,
  input  logic [95:0] SUM_OUT,
  output logic        RES0_VALID,
  output logic [95:0] RES0_DATA,
  output logic        RES1_VALID,
  output logic [95:0] RES1_DATA
);

  // One tag per in-flight operation: whether the slot carries a real op and
  // which requester it belongs to.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic ptr;          // round-robin pointer: requester that wins a tie
  logic grant_any;    // an operation is accepted at the coming edge
  logic grant_id;     // requester being granted
  tag_t op_tag;       // tag travelling with the AIN/BIN/ADD_SUB register
  tag_t tag_pipe [LAT];  // one slot per adder pipeline stage
  tag_t exit_tag;     // tag whose result is on SUM_OUT this cycle

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if (!RST) begin
      REQ0_READY = REQ0_VALID && (!REQ1_VALID || (ptr == 1'b0));
      REQ1_READY = REQ1_VALID && (!REQ0_VALID || (ptr == 1'b1));
    end
    grant_any = REQ0_READY || REQ1_READY;
    grant_id  = REQ1_READY;
  end

  // Pointer moves to the requester that lost, only when something was accepted.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= 1'b0;
    end else if (grant_any) begin
      ptr <= ~grant_id;
    end
  end

  // Operand register toward the shared adder; holds when nothing is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AIN     <= '0;
      BIN     <= '0;
      ADD_SUB <= 1'b0;
    end else if (grant_any) begin
      AIN     <= grant_id ? REQ1_A   : REQ0_A;
      BIN     <= grant_id ? REQ1_B   : REQ0_B;
      ADD_SUB <= grant_id ? REQ1_SUB : REQ0_SUB;
    end
  end

  // Tag tracking: op_tag pairs with the operand register, then tag_pipe follows
  // the operation through the adder's LAT stages so the exiting tag lines up
  // with the matching SUM_OUT. Every cycle shifts; idle cycles insert bubbles.
  // NOTE: the tag array holds valid bits, so unlike a data-only memory it must be reset entry by entry to drop in-flight work.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_tag <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      op_tag.vld  <= grant_any;
      op_tag.id   <= grant_id;
      tag_pipe[0] <= op_tag;
      for (int i = 1; i < LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign exit_tag = tag_pipe[LAT-1];

  // Result return: capture SUM_OUT for the owning requester and strobe once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES0_VALID <= 1'b0;
      RES1_VALID <= 1'b0;
      RES0_DATA  <= '0;
      RES1_DATA  <= '0;
    end else begin
      RES0_VALID <= exit_tag.vld && (exit_tag.id == 1'b0);
      RES1_VALID <= exit_tag.vld && (exit_tag.id == 1'b1);
      if (exit_tag.vld && (exit_tag.id == 1'b0)) begin
        RES0_DATA <= SUM_OUT;
      end
      if (exit_tag.vld && (exit_tag.id == 1'b1)) begin
        RES1_DATA <= SUM_OUT;
      end
    end
  end

endmodule

// File: tb/tb_addsub96_arb.sv
// Self-checking bench for addsub96_arb: a behavioural model of the shared adder
// drives SUM_OUT, and a queue-based scoreboard predicts grants, operand
// registers and result strobes from the arbitration rules.
module tb_addsub96_arb;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [94:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic        REQ0_SUB, REQ1_SUB;
  logic [94:0] AIN, BIN;
  logic        ADD_SUB;
  logic [95:0] SUM_OUT;
  logic        RES0_VALID, RES1_VALID;
  logic [95:0] RES0_DATA, RES1_DATA;

  always #5 CLK = ~CLK;

  addsub96_arb #(.LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_SUB(REQ0_SUB),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_SUB(REQ1_SUB),
    .AIN(AIN), .BIN(BIN), .ADD_SUB(ADD_SUB), .SUM_OUT(SUM_OUT),
    .RES0_VALID(RES0_VALID), .RES0_DATA(RES0_DATA),
    .RES1_VALID(RES1_VALID), .RES1_DATA(RES1_DATA)
  );

  // Adder arithmetic: zero-extended operands, result modulo 2^96.
  function automatic logic [95:0] ref_result(input logic [94:0] a, input logic [94:0] b,
                                             input logic sub);
    logic [95:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  // Shared adder model: LAT register stages behind AIN/BIN/ADD_SUB.
  logic [95:0] add_pipe [LAT];
  always @(posedge CLK) begin
    add_pipe[0] <= ref_result(AIN, BIN, ADD_SUB);
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign SUM_OUT = add_pipe[LAT-1];

  typedef struct {
    logic        id;
    logic [95:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          n_vec;
  int          n_err;
  logic        m_ptr;
  logic [94:0] m_ain, m_bin;
  logic        m_sub;
  logic [95:0] m_last [2];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check READY after inputs settle, update the model at the edge,
  // then check registered outputs just after it.
  task automatic tick();
    logic        exp_r0, exp_r1, rst_now;
    logic [1:0]  exp_v;
    exp_t        e;
    #1;
    exp_r0  = 1'b0;
    exp_r1  = 1'b0;
    rst_now = RST;
    if (!rst_now) begin
      if (REQ0_VALID && REQ1_VALID) begin
        if (m_ptr) exp_r1 = 1'b1;
        else       exp_r0 = 1'b1;
      end else begin
        exp_r0 = REQ0_VALID;
        exp_r1 = REQ1_VALID;
      end
    end
    check("ready0", REQ0_READY, exp_r0);
    check("ready1", REQ1_READY, exp_r1);
    @(posedge CLK);
    cyc++;
    if (rst_now) begin
      m_ptr = 1'b0;
      sb.delete();
      m_ain = '0;
      m_bin = '0;
      m_sub = 1'b0;
      m_last[0] = '0;
      m_last[1] = '0;
    end else if (exp_r0 || exp_r1) begin
      e.id   = exp_r1;
      e.data = exp_r1 ? ref_result(REQ1_A, REQ1_B, REQ1_SUB)
                      : ref_result(REQ0_A, REQ0_B, REQ0_SUB);
      e.due  = cyc + LAT + 1;
      sb.push_back(e);
      m_ptr = ~exp_r1;
      m_ain = exp_r1 ? REQ1_A   : REQ0_A;
      m_bin = exp_r1 ? REQ1_B   : REQ0_B;
      m_sub = exp_r1 ? REQ1_SUB : REQ0_SUB;
    end
    #1;
    exp_v = 2'b00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_v[e.id] = 1'b1;
      m_last[e.id] = e.data;
    end
    check("res0_valid", RES0_VALID, exp_v[0]);
    check("res1_valid", RES1_VALID, exp_v[1]);
    check("res0_data", RES0_DATA, m_last[0]);
    check("res1_data", RES1_DATA, m_last[1]);
    check("ain", AIN, m_ain);
    check("bin", BIN, m_bin);
    check("add_sub", ADD_SUB, m_sub);
    @(negedge CLK);
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [94:0] a0,
                       input logic [94:0] b0, input logic s0, input logic v1,
                       input logic [94:0] a1, input logic [94:0] b1, input logic s1);
    RST = rst;
    REQ0_VALID = v0; REQ0_A = a0; REQ0_B = b0; REQ0_SUB = s0;
    REQ1_VALID = v1; REQ1_A = a1; REQ1_B = b1; REQ1_SUB = s1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Random operand with extra weight on the all-zero and all-one corners.
  function automatic logic [94:0] rnd95();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return t[94:0];
    endcase
  endfunction

  localparam logic [94:0] OP_A = 95'd281474976710665;  // 2^48 + 9
  localparam logic [94:0] OP_B = 95'd10;

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    m_ptr = 1'b0; m_ain = '0; m_bin = '0; m_sub = 1'b0;
    m_last[0] = '0; m_last[1] = '0;
    RST = 1'b1;
    REQ0_VALID = 1'b0; REQ0_A = '0; REQ0_B = '0; REQ0_SUB = 1'b0;
    REQ1_VALID = 1'b0; REQ1_A = '0; REQ1_B = '0; REQ1_SUB = 1'b0;
    @(negedge CLK);

    // Reset with both requesters asserting: READY must stay low.
    drive(1'b1, 1'b1, rnd95(), rnd95(), 1'b0, 1'b1, rnd95(), rnd95(), 1'b1);
    drive(1'b1, 1'b1, rnd95(), rnd95(), 1'b1, 1'b1, rnd95(), rnd95(), 1'b0);

    // Single add from REQ0, accepted at the first edge with RST low.
    drive(1'b0, 1'b1, OP_A, OP_B, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(LAT + 2);
    check("dir_add", RES0_DATA, 96'h0000_0000_0001_0000_0000_0013);

    // Subtract across the 48-bit boundary, then 0 - 1 wrapping to all ones.
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, OP_A, OP_B, 1'b1);
    idle(LAT + 2);
    check("dir_sub", RES1_DATA, 96'h0000_0000_0000_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 95'd0, 95'd1, 1'b1);
    idle(LAT + 2);
    check("dir_wrap", RES1_DATA, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);

    // Contention straight after reset: grants alternate starting at REQ0.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, rnd95(), rnd95(), i[0], 1'b1, rnd95(), rnd95(), ~i[0]);
    idle(LAT + 2);

    // Single requester streaming: pointer must not block REQ0.
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rnd95(), rnd95(), 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, rnd95(), rnd95(), i[1], 1'b0, '0, '0, 1'b0);
    idle(LAT + 2);

    // Reset one edge after an acceptance: the op is dropped.
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rnd95(), rnd95(), 1'b1);
    drive(1'b0, 1'b1, rnd95(), rnd95(), 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(LAT + 3);
    drive(1'b0, 1'b1, rnd95(), rnd95(), 1'b0, 1'b1, rnd95(), rnd95(), 1'b1);
    idle(LAT + 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), rnd95(), rnd95(),
            1'($urandom), ($urandom_range(0, 2) != 0), rnd95(), rnd95(), 1'($urandom));
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub96_arb.md
ADDSUB96_ARB -- requirements
Module: addsub96_arb

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the cycle count from a registered AIN/BIN/ADD_SUB change to the matching SUM_OUT; legal range 1..8.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports REQ0_VALID / REQ1_VALID, input, 1 bit each: requester has an operation pending.
REQ-005 SHALL have ports REQ0_READY / REQ1_READY, output, 1 bit each: operation accepted this cycle.
REQ-006 SHALL have ports REQ0_A, REQ0_B, REQ1_A, REQ1_B, input, 95 bits each: operands.
REQ-007 SHALL have ports REQ0_SUB / REQ1_SUB, input, 1 bit each: 0 = A+B, 1 = A-B.
REQ-008 SHALL have ports AIN / BIN, output, 95 bits each: registered operands to the shared adder.
REQ-009 SHALL have port ADD_SUB, output, 1 bit: registered mode to the shared adder.
REQ-010 SHALL have port SUM_OUT, input, 96 bits: result from the shared adder.
REQ-011 SHALL have ports RES0_VALID / RES1_VALID, output, 1 bit each: one-cycle result strobe per requester.
REQ-012 SHALL have ports RES0_DATA / RES1_DATA, output, 96 bits each: result, held until the next strobe.

Function
REQ-013 SHALL accept an operation when VALID and READY are both high at a rising edge; at most one acceptance per cycle.
REQ-014 SHALL drive READY combinationally:
- READYx = VALIDx AND NOT RST AND (other VALID low, or round-robin pointer = x).
REQ-015 SHALL keep a 1-bit round-robin pointer:
- After each acceptance, the pointer is set to the non-granted requester.
- With no acceptance, the pointer holds.
REQ-016 SHALL, on acceptance, register AIN, BIN and ADD_SUB from the granted requester's A, B and SUB at that same edge.
- With no acceptance, these outputs hold their values.
REQ-017 SHALL keep a LAT-deep tag shift register (valid bit plus requester id), advanced every cycle.
- The entry is loaded with valid=1 and the granted id on acceptance, otherwise with valid=0.
REQ-018 SHALL capture SUM_OUT into RESx_DATA when the tag exiting the pipe is valid with id x, and pulse RESx_VALID high for exactly one cycle.
REQ-019 Total latency SHALL be LAT+1 cycles:
- For acceptance at edge N, RESx_VALID is high in the cycle following edge N+LAT+1.
REQ-020 SHALL forward SUM_OUT unmodified.
- Arithmetic is defined by the shared adder: zero-extended operands, result modulo 2^96.
REQ-021 SHALL sustain one operation per cycle, including back-to-back ops alternating requesters; results return in acceptance order.
REQ-022 Results SHALL have no backpressure; a requester must sample RESx_VALID every cycle.
REQ-023 A requester that deasserts VALID without a handshake SHALL leave no trace: pointer, tags and outputs are unchanged.

Reset
REQ-024 While RST is high at an edge, the block SHALL set:
- pointer = 0;
- all tag entries invalid;
- AIN = 0, BIN = 0, ADD_SUB = 0;
- RESx_VALID = 0, RESx_DATA = 0.
REQ-025 While RST is high, READY0 and READY1 SHALL be 0.
REQ-026 Operations in flight when RST asserts SHALL be dropped; no RESx_VALID is produced for them after reset releases.
REQ-027 The first acceptance SHALL be possible at the first edge with RST low.

Verification
REQ-028 Single add:
- Stimulus: REQ0 A=281474976710665 (2^48+9), B=10, SUB=0, LAT=2, accepted at edge N.
- Response: RES0_VALID high after edge N+3; RES0_DATA = 0x0000_0000_0001_0000_0000_0013.
REQ-029 Subtract across the 48-bit boundary:
- Stimulus: REQ1 same operands, SUB=1.
- Response: RES1_DATA = 0x0000_0000_0000_FFFF_FFFF_FFFF.
- Also: REQ1 A=0, B=1, SUB=1 returns 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF.
REQ-030 Contention:
- Stimulus: both VALID held high for 6 cycles after reset.
- Response: grants are 0,1,0,1,0,1; six results return in that order, one per cycle; ADD_SUB follows each requester's SUB.
REQ-031 Single requester streaming:
- Stimulus: REQ0 VALID high for 4 cycles, REQ1 idle.
- Response: 4 consecutive REQ0 acceptances; the pointer does not block REQ0.
REQ-032 Reset mid-flight:
- Stimulus: RST pulsed for 1 cycle one edge after an acceptance.
- Response: no RESx_VALID within LAT+3 cycles; AIN = BIN = 0 after the reset edge; next grant goes to REQ0 under contention.
